// File: rtl/game_flow_ctrl.sv
// Game-flow FSM: idle / play / pause / respawn / game-over with lives.
// Drives the game-wide clear and run enable for the datapath blocks.
module game_flow_ctrl #(
    parameter int LIVES         = 3,
    parameter int LIFE_W        = 2,
    parameter int RESPAWN_TICKS = 8,
    parameter int CNT_W         = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              jump,
    input  logic              pause,
    input  logic              restart,
    input  logic              dead,
    output logic              game_reset,
    output logic              enable,
    output logic              respawn,
    output logic              game_over,
    output logic [LIFE_W-1:0] lives_left,
    output logic [2:0]        state_code
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PLAY    = 3'd1,
        S_PAUSE   = 3'd2,
        S_RESPAWN = 3'd3,
        S_OVER    = 3'd4
    } state_t;

    localparam logic [LIFE_W-1:0] LIVES_INIT = LIFE_W'(LIVES);
    localparam logic [LIFE_W-1:0] ONE_LIFE   = LIFE_W'(1);
    localparam logic [CNT_W-1:0]  CNT_INIT   = CNT_W'(RESPAWN_TICKS - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = '0;

    state_t            r_state;
    logic [LIFE_W-1:0] r_lives;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_jump_q;
    logic              r_pause_q;
    logic              r_restart_q;
    logic              r_dead_q;

    logic w_jump_rise;
    logic w_pause_rise;
    logic w_restart_rise;
    logic w_dead_rise;

    assign w_jump_rise    = jump    & ~r_jump_q;
    assign w_pause_rise   = pause   & ~r_pause_q;
    assign w_restart_rise = restart & ~r_restart_q;
    assign w_dead_rise    = dead    & ~r_dead_q;

    // Input delay flops; they track inputs in every state so a held
    // level never produces a second event later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_jump_q    <= 1'b0;
            r_pause_q   <= 1'b0;
            r_restart_q <= 1'b0;
            r_dead_q    <= 1'b0;
        end else begin
            r_jump_q    <= jump;
            r_pause_q   <= pause;
            r_restart_q <= restart;
            r_dead_q    <= dead;
        end
    end

    // Game state, lives and respawn countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_lives <= LIVES_INIT;
            r_cnt   <= CNT_ZERO;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_jump_rise) begin
                        r_state <= S_PLAY;
                        r_lives <= LIVES_INIT;
                    end
                end
                S_PLAY: begin
                    if (w_restart_rise) begin
                        r_state <= S_IDLE;
                    end else if (w_dead_rise) begin
                        if (r_lives <= ONE_LIFE) begin
                            r_state <= S_OVER;
                            r_lives <= '0;
                        end else begin
                            r_state <= S_RESPAWN;
                            r_lives <= r_lives - ONE_LIFE;
                            r_cnt   <= CNT_INIT;
                        end
                    end else if (w_pause_rise) begin
                        r_state <= S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (w_restart_rise) begin
                        r_state <= S_IDLE;
                    end else if (w_pause_rise) begin
                        r_state <= S_PLAY;
                    end
                end
                S_RESPAWN: begin
                    if (w_restart_rise) begin
                        r_state <= S_IDLE;
                    end else if (tick) begin
                        if (r_cnt == CNT_ZERO) begin
                            r_state <= S_PLAY;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                S_OVER: begin
                    if (w_jump_rise || w_restart_rise) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Moore decode of the state register; unknown codes read as idle.
    always_comb begin
        game_reset = 1'b0;
        enable     = 1'b0;
        respawn    = 1'b0;
        game_over  = 1'b0;
        case (r_state)
            S_IDLE:    game_reset = 1'b1;
            S_PLAY:    enable     = 1'b1;
            S_PAUSE:   ;
            S_RESPAWN: respawn    = 1'b1;
            S_OVER:    game_over  = 1'b1;
            default:   game_reset = 1'b1;
        endcase
    end

    assign lives_left = r_lives;
    assign state_code = r_state;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: reset, start, deaths, respawn
// timing, event priority, pause freeze and reset during respawn.
module tb_game_flow_ctrl;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       jump;
    logic       pause;
    logic       restart;
    logic       dead;
    logic       game_reset;
    logic       enable;
    logic       respawn;
    logic       game_over;
    logic [1:0] lives_left;
    logic [2:0] state_code;

    int n_tests;
    int n_fail;

    game_flow_ctrl #(
        .LIVES(3),
        .LIFE_W(2),
        .RESPAWN_TICKS(8),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .jump(jump),
        .pause(pause),
        .restart(restart),
        .dead(dead),
        .game_reset(game_reset),
        .enable(enable),
        .respawn(respawn),
        .game_over(game_over),
        .lives_left(lives_left),
        .state_code(state_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_tests++;
        if (state_code !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want 0", state_code);
        end
        n_tests++;
        if ({game_reset, enable, respawn, game_over} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_outs: got %b want 1000",
                     {game_reset, enable, respawn, game_over});
        end
        n_tests++;
        if (lives_left !== 2'd3) begin
            n_fail++;
            $display("FAIL reset_lives: got %0d want 3", lives_left);
        end
    endtask

    task automatic test_start();
        jump = 1'b1;
        cyc();
        n_tests++;
        if (state_code !== 3'd1 || enable !== 1'b1) begin
            n_fail++;
            $display("FAIL start_play: state %0d en %b want 1 1",
                     state_code, enable);
        end
        n_tests++;
        if (lives_left !== 2'd3) begin
            n_fail++;
            $display("FAIL start_lives: got %0d want 3", lives_left);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_tests++;
            if (state_code !== 3'd1) begin
                n_fail++;
                $display("FAIL start_hold%0d: state %0d want 1",
                         i, state_code);
            end
        end
        jump = 1'b0;
        cyc();
    endtask

    task automatic test_deaths();
        logic [1:0] exp_l [3];
        logic [2:0] exp_s [3];
        exp_l[0] = 2'd2; exp_l[1] = 2'd1; exp_l[2] = 2'd0;
        exp_s[0] = 3'd3; exp_s[1] = 3'd3; exp_s[2] = 3'd4;
        for (int d = 0; d < 3; d++) begin
            dead = 1'b1;
            cyc();
            dead = 1'b0;
            n_tests++;
            if (state_code !== exp_s[d] || lives_left !== exp_l[d]) begin
                n_fail++;
                $display("FAIL death%0d: state %0d lives %0d want %0d %0d",
                         d, state_code, lives_left, exp_s[d], exp_l[d]);
            end
            cyc();
            for (int t = 0; t < 8; t++) tick_pulse();
            if (d < 2) begin
                n_tests++;
                if (state_code !== 3'd1) begin
                    n_fail++;
                    $display("FAIL death%0d_back: state %0d want 1",
                             d, state_code);
                end
            end
        end
        n_tests++;
        if (game_over !== 1'b1 || enable !== 1'b0) begin
            n_fail++;
            $display("FAIL over_outs: go %b en %b want 1 0",
                     game_over, enable);
        end
        jump = 1'b1;
        cyc();
        jump = 1'b0;
        n_tests++;
        if (state_code !== 3'd0 || game_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL over_exit: state %0d gr %b want 0 1",
                     state_code, game_reset);
        end
        cyc();
        jump = 1'b1;
        cyc();
        jump = 1'b0;
        n_tests++;
        if (state_code !== 3'd1 || lives_left !== 2'd3) begin
            n_fail++;
            $display("FAIL reload: state %0d lives %0d want 1 3",
                     state_code, lives_left);
        end
        cyc();
    endtask

    task automatic test_respawn_timing();
        dead = 1'b1;
        cyc();
        dead = 1'b0;
        n_tests++;
        if (respawn !== 1'b1 || enable !== 1'b0 || lives_left !== 2'd2) begin
            n_fail++;
            $display("FAIL rsp_enter: rsp %b en %b lives %0d want 1 0 2",
                     respawn, enable, lives_left);
        end
        for (int i = 1; i <= 8; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            if (i < 8) begin
                n_tests++;
                if (respawn !== 1'b1 || enable !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rsp_tick%0d: rsp %b en %b want 1 0",
                             i, respawn, enable);
                end
            end else begin
                n_tests++;
                if (state_code !== 3'd1 || enable !== 1'b1 ||
                    respawn !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rsp_done: state %0d en %b rsp %b want 1 1 0",
                             state_code, enable, respawn);
                end
            end
            cyc();
        end
    endtask

    task automatic test_same_cycle();
        restart = 1'b1;
        dead    = 1'b1;
        pause   = 1'b1;
        cyc();
        restart = 1'b0;
        dead    = 1'b0;
        pause   = 1'b0;
        n_tests++;
        if (state_code !== 3'd0 || game_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_state: state %0d gr %b want 0 1",
                     state_code, game_reset);
        end
        n_tests++;
        if (lives_left !== 2'd2) begin
            n_fail++;
            $display("FAIL prio_lives: got %0d want 2", lives_left);
        end
        cyc();
    endtask

    task automatic test_pause();
        jump = 1'b1;
        cyc();
        jump = 1'b0;
        cyc();
        pause = 1'b1;
        cyc();
        n_tests++;
        if (state_code !== 3'd2 || enable !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_enter: state %0d en %b want 2 0",
                     state_code, enable);
        end
        dead = 1'b1;
        for (int t = 0; t < 20; t++) tick_pulse();
        n_tests++;
        if (state_code !== 3'd2 || lives_left !== 2'd3) begin
            n_fail++;
            $display("FAIL pause_freeze: state %0d lives %0d want 2 3",
                     state_code, lives_left);
        end
        pause = 1'b0;
        cyc();
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        n_tests++;
        if (state_code !== 3'd1 || lives_left !== 2'd3) begin
            n_fail++;
            $display("FAIL pause_exit: state %0d lives %0d want 1 3",
                     state_code, lives_left);
        end
        cyc();
        dead = 1'b0;
        cyc();
    endtask

    task automatic test_rst_mid_respawn();
        dead = 1'b1;
        cyc();
        dead = 1'b0;
        tick_pulse();
        pause = 1'b1;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        pause = 1'b0;
        n_tests++;
        if (state_code !== 3'd3 || dut.r_cnt !== 4'd5) begin
            n_fail++;
            $display("FAIL rsp_mid: state %0d cnt %0d want 3 5",
                     state_code, dut.r_cnt);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_tests++;
        if (state_code !== 3'd0 || lives_left !== 2'd3 ||
            respawn !== 1'b0 || dut.r_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_rsp: st %0d lv %0d rsp %b cnt %0d want 0 3 0 0",
                     state_code, lives_left, respawn, dut.r_cnt);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        tick    = 1'b0;
        jump    = 1'b0;
        pause   = 1'b0;
        restart = 1'b0;
        dead    = 1'b0;
        cyc();
        test_reset();
        test_start();
        test_deaths();
        test_respawn_timing();
        test_same_cycle();
        test_pause();
        test_rst_mid_respawn();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
